// File: rtl/qnigma_tx_arb.sv
// qnigma_tx_arb: N-channel request/grant arbiter in front of qnigma_tx.
// Fixed-priority or round-robin selection with a per-transfer millisecond watchdog.
module qnigma_tx_arb #(
    parameter int N          = 4,
    parameter int MODE       = 1,
    parameter int TIMEOUT_MS = 10,
    parameter int PROTO_W    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_ms,
    input  logic [N-1:0]           req,
    input  logic [N*PROTO_W-1:0]   proto_in,
    output logic [N-1:0]           gnt,
    output logic [$clog2(N)-1:0]   sel,
    output logic                   send,
    output logic [PROTO_W-1:0]     proto,
    input  logic                   tx_busy,
    input  logic                   tx_done,
    output logic [N-1:0]           done_out,
    output logic [N-1:0]           abort_out,
    output logic                   arb_busy
);
    localparam int SW = $clog2(N);
    localparam int CW = TIMEOUT_MS > 0 ? $clog2(TIMEOUT_MS + 1) : 1;
    localparam logic [CW-1:0] LIM = CW'(TIMEOUT_MS > 0 ? TIMEOUT_MS - 1 : 0);
    localparam logic [SW:0] NN = (SW + 1)'(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

    state_t state, nxt;
    logic [SW-1:0] ptr, ptr_d, sel_d, base, off, win, nptr;
    logic [SW:0] sum;
    logic [N-1:0] rot, gnt_d, done_d, abort_d, sel_oh;
    logic [PROTO_W-1:0] proto_d;
    logic [PROTO_W-1:0] pin [N];
    logic [CW-1:0] cnt, cnt_d;
    logic found, expire;

    for (genvar g = 0; g < N; g++) begin : g_pin
        assign pin[g] = proto_in[g*PROTO_W +: PROTO_W];
    end

    // rotate so the search always starts at bit 0; fixed priority never rotates
    assign base = MODE != 0 ? ptr : '0;
    assign rot  = N'({req, req} >> base);

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                off   = SW'(i);
                found = 1'b1;
            end
        end
    end

    assign sum    = {1'b0, base} + {1'b0, off};
    assign win    = sum >= NN ? SW'(sum - NN) : SW'(sum);
    assign nptr   = sel == LAST ? '0 : sel + 1'b1;
    assign sel_oh = N'(1) << sel;
    assign expire = TIMEOUT_MS != 0 && tick_ms && cnt == LIM;

    always_comb begin
        nxt     = state;
        gnt_d   = gnt;
        sel_d   = sel;
        proto_d = proto;
        ptr_d   = ptr;
        cnt_d   = cnt;
        done_d  = '0;
        abort_d = '0;
        case (state)
            // a grant left over from RELEASE is dropped first, guaranteeing a gap between grants
            IDLE: begin
                if (|gnt) begin
                    gnt_d = '0;
                end else if (|req) begin
                    nxt     = SEND;
                    gnt_d   = N'(1) << win;
                    sel_d   = win;
                    proto_d = pin[win];
                    cnt_d   = '0;
                end
            end
            SEND: nxt = WAIT_BUSY;
            WAIT_BUSY, WAIT_DONE: begin
                cnt_d = cnt + CW'(tick_ms);
                if (tx_done) begin
                    nxt = RELEASE;
                end else if (expire) begin
                    nxt     = IDLE;
                    abort_d = sel_oh;
                    gnt_d   = '0;
                    ptr_d   = nptr;
                end else if (state == WAIT_BUSY && tx_busy) begin
                    nxt = WAIT_DONE;
                end
            end
            RELEASE: begin
                nxt    = IDLE;
                done_d = sel_oh;
                ptr_d  = nptr;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            sel       <= '0;
            proto     <= '0;
            ptr       <= '0;
            cnt       <= '0;
            send      <= 1'b0;
            done_out  <= '0;
            abort_out <= '0;
            arb_busy  <= 1'b0;
        end else begin
            state     <= nxt;
            gnt       <= gnt_d;
            sel       <= sel_d;
            proto     <= proto_d;
            ptr       <= ptr_d;
            cnt       <= cnt_d;
            send      <= state == SEND;
            done_out  <= done_d;
            abort_out <= abort_d;
            arb_busy  <= nxt != IDLE;
        end
    end
endmodule

// File: tb/tb_qnigma_tx_arb.sv
// tb_qnigma_tx_arb: round-robin and fixed-priority instances share stimulus;
// a transfer-level model predicts winners and the cycle of every output event.
module tb_qnigma_tx_arb;
    logic clk = 1'b0;
    logic rst, tick_ms, tx_busy, tx_done;
    logic [3:0] req, gnt, f_gnt, done_out, f_done, abort_out, f_abort;
    logic [11:0] proto_in;
    logic [1:0] sel, f_sel;
    logic [2:0] proto, f_proto;
    logic send, f_send, arb_busy, f_busy;
    int checks = 0, errors = 0, ptr_m = 0, gr, gf;

    always #5 clk = ~clk;

    qnigma_tx_arb #(.N(4), .MODE(1), .TIMEOUT_MS(3), .PROTO_W(3)) dut (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .req(req), .proto_in(proto_in),
        .gnt(gnt), .sel(sel), .send(send), .proto(proto), .tx_busy(tx_busy),
        .tx_done(tx_done), .done_out(done_out), .abort_out(abort_out), .arb_busy(arb_busy)
    );

    qnigma_tx_arb #(.N(4), .MODE(0), .TIMEOUT_MS(3), .PROTO_W(3)) dut_fp (
        .clk(clk), .rst(rst), .tick_ms(tick_ms), .req(req), .proto_in(proto_in),
        .gnt(f_gnt), .sel(f_sel), .send(f_send), .proto(f_proto), .tx_busy(tx_busy),
        .tx_done(tx_done), .done_out(f_done), .abort_out(f_abort), .arb_busy(f_busy)
    );

    typedef struct {
        logic [3:0]  r;
        logic [11:0] p;
        logic [63:0] dm;
        logic [63:0] tm;
        bit          hold;
        bit          drop;
        int          rr;
        int          fp;
    } vec_t;

    vec_t tbl [15];

    function automatic int rr_win(input logic [3:0] r, input int ptr);
        for (int k = 0; k < 4; k++) if (r[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    function automatic int fp_win(input logic [3:0] r);
        for (int k = 0; k < 4; k++) if (r[k]) return k;
        return -1;
    endfunction

    function automatic logic [2:0] proto_of(input logic [11:0] p, input int c);
        return 3'(p >> (3 * c));
    endfunction

    function automatic logic [63:0] bit_at(input int n);
        return 64'd1 << n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_gnt"}, gnt, 0);       chk({t, "_f_gnt"}, f_gnt, 0);
        chk({t, "_sel"}, sel, 0);       chk({t, "_f_sel"}, f_sel, 0);
        chk({t, "_send"}, send, 0);     chk({t, "_f_send"}, f_send, 0);
        chk({t, "_proto"}, proto, 0);   chk({t, "_f_proto"}, f_proto, 0);
        chk({t, "_done"}, done_out, 0); chk({t, "_f_done"}, f_done, 0);
        chk({t, "_abort"}, abort_out, 0); chk({t, "_f_abort"}, f_abort, 0);
        chk({t, "_busy"}, arb_busy, 0); chk({t, "_f_busy"}, f_busy, 0);
    endtask

    // dm/tm bit x: tx_done / tick_ms sampled at edge x after the transfer starts.
    // Call just after an edge with both arbiters idle and gnt low.
    task automatic xfer(input logic [3:0] r, input logic [11:0] p, input logic [63:0] dm,
                        input logic [63:0] tm, input bit hold, input bit drop,
                        output int g_rr, output int g_fp);
        int wr, wf, j, cnt, last, bend;
        bit rel;
        wr = rr_win(r, ptr_m);
        wf = fp_win(r);
        j = 0; cnt = 0; rel = 1'b0;
        // waiting starts after SEND, so only edges from 3 on can complete or count ticks
        for (int x = 3; x < 64 && j == 0; x++) begin
            if (dm[x]) begin
                j = x;
                rel = 1'b1;
            end else if (tm[x]) begin
                cnt++;
                if (cnt == 3) j = x;
            end
        end
        last = rel ? j + 2 : j;
        bend = rel ? j + 1 : j;
        g_rr = -1; g_fp = -1;
        req = r;
        proto_in = p;
        for (int x = 1; x <= last; x++) begin
            tx_done = dm[x];
            tick_ms = tm[x];
            tx_busy = 1'($urandom);
            @(posedge clk); #1;
            chk("gnt", gnt, x < last ? 32'(1 << wr) : 0);
            chk("f_gnt", f_gnt, x < last ? 32'(1 << wf) : 0);
            if (x < last) begin
                chk("sel", sel, wr);        chk("f_sel", f_sel, wf);
                chk("proto", proto, proto_of(p, wr));
                chk("f_proto", f_proto, proto_of(p, wf));
            end
            chk("send", send, x == 2);      chk("f_send", f_send, x == 2);
            chk("done", done_out, rel && x == j + 1 ? 32'(1 << wr) : 0);
            chk("f_done", f_done, rel && x == j + 1 ? 32'(1 << wf) : 0);
            chk("abort", abort_out, !rel && x == j ? 32'(1 << wr) : 0);
            chk("f_abort", f_abort, !rel && x == j ? 32'(1 << wf) : 0);
            chk("busy", arb_busy, x < bend);
            chk("f_busy", f_busy, x < bend);
            if (x == 1) begin
                g_rr = int'(sel);
                g_fp = int'(f_sel);
                proto_in = 12'($urandom);
                if (drop) req = 4'b0;
            end
            if (x == bend && !hold) req = 4'b0;
        end
        tx_done = 1'b0;
        tick_ms = 1'b0;
        ptr_m = (wr + 1) % 4;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] r;
        logic [63:0] dm, tm;
        tbl[0]  = '{4'b0100, 12'h080, bit_at(24), 64'd0, 1'b0, 1'b0, 2, 2};
        tbl[1]  = '{4'b1000, 12'h5a3, bit_at(4), 64'd0, 1'b0, 1'b0, 3, 3};
        tbl[2]  = '{4'b1111, 12'h123, bit_at(4), 64'd0, 1'b1, 1'b0, 0, 0};
        tbl[3]  = '{4'b1111, 12'h456, bit_at(4), 64'd0, 1'b1, 1'b0, 1, 0};
        tbl[4]  = '{4'b1111, 12'h789, bit_at(4), 64'd0, 1'b1, 1'b0, 2, 0};
        tbl[5]  = '{4'b1111, 12'habc, bit_at(4), 64'd0, 1'b1, 1'b0, 3, 0};
        tbl[6]  = '{4'b1111, 12'hdef, bit_at(4), 64'd0, 1'b1, 1'b0, 0, 0};
        tbl[7]  = '{4'b1111, 12'h321, bit_at(4), 64'd0, 1'b1, 1'b0, 1, 0};
        tbl[8]  = '{4'b1110, 12'h654, bit_at(4), 64'd0, 1'b1, 1'b0, 2, 1};
        tbl[9]  = '{4'b1110, 12'h987, bit_at(4), 64'd0, 1'b1, 1'b0, 3, 1};
        tbl[10] = '{4'b1110, 12'hcba, bit_at(4), 64'd0, 1'b0, 1'b0, 1, 1};
        tbl[11] = '{4'b1010, 12'hf0f, bit_at(6), 64'd0, 1'b0, 1'b1, 3, 1};
        tbl[12] = '{4'b0011, 12'h0f0, 64'd0, bit_at(5) | bit_at(7) | bit_at(9), 1'b0, 1'b0, 0, 0};
        tbl[13] = '{4'b0011, 12'h3c3, bit_at(9), bit_at(5) | bit_at(7) | bit_at(9), 1'b0, 1'b0, 1, 0};
        tbl[14] = '{4'b0101, 12'h777, bit_at(1) | bit_at(2) | bit_at(6),
                    bit_at(2) | bit_at(3) | bit_at(4), 1'b0, 1'b0, 2, 0};

        rst = 1'b0; req = '0; proto_in = '0; tick_ms = 1'b0; tx_busy = 1'b0; tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        #3 rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            xfer(tbl[i].r, tbl[i].p, tbl[i].dm, tbl[i].tm, tbl[i].hold, tbl[i].drop, gr, gf);
            chk($sformatf("tbl%0d_rr", i), gr, tbl[i].rr);
            chk($sformatf("tbl%0d_fp", i), gf, tbl[i].fp);
        end

        // reset while waiting on tx_done: outputs clear without waiting for a clock
        req = 4'b0100; proto_in = 12'h1c0; tx_busy = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("pre_rst_gnt", gnt, 4'b0100);
        chk("pre_rst_busy", arb_busy, 1);
        #2 rst = 1'b0;
        #1 chk_idle("rst_async");
        req = '0; tx_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_idle("rst_hold");
        #3 rst = 1'b1;
        @(posedge clk); #1;
        chk_idle("rst_rel");
        ptr_m = 0;
        xfer(4'b1111, 12'h2b4, bit_at(4), 64'd0, 1'b0, 1'b0, gr, gf);
        chk("post_rst_rr", gr, 0);
        xfer(4'b0001, 12'h9e1, bit_at(5), 64'd0, 1'b0, 1'b0, gr, gf);
        chk("post_rst_ch0", gr, 0);

        for (int t = 0; t < 40; t++) begin
            r = 4'($urandom_range(15, 1));
            dm = '0;
            tm = '0;
            if ($urandom_range(2) != 0) dm |= bit_at(int'($urandom_range(45, 3)));
            if ($urandom_range(1) != 0) dm |= bit_at(1);
            if ($urandom_range(1) != 0) dm |= bit_at(2);
            for (int x = 1; x < 64; x++)
                if ($urandom_range(3) == 0 || x % 16 == 0) tm |= bit_at(x);
            xfer(r, 12'($urandom), dm, tm, 1'($urandom), $urandom_range(3) == 0, gr, gf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
